// File: rtl/enet_mdio_pkg.sv
// enet_mdio_pkg: shared state type, Clause 22 frame constants and frame builder
// for the MDIO management controller.
package enet_mdio_pkg;

    typedef enum logic [2:0] {RST_HOLD, RST_WAIT, IDLE, SHIFT, DONE} mdio_state_e;

    localparam int         MDIO_FRAME_BITS = 64;
    localparam logic [1:0] MDIO_OP_READ    = 2'b10;
    localparam logic [1:0] MDIO_OP_WRITE   = 2'b01;
    localparam int         MDIO_TA_BIT     = 47;
    localparam int         MDIO_DATA_FIRST = 48;

    // Released read bits are filled with ones, matching the idle pull-up level.
    function automatic logic [MDIO_FRAME_BITS-1:0] mdio_frame(
        input logic        wr,
        input logic [4:0]  phy,
        input logic [4:0]  rg,
        input logic [15:0] wdata
    );
        return {32'hFFFF_FFFF, 2'b01, wr ? MDIO_OP_WRITE : MDIO_OP_READ, phy, rg,
                wr ? 2'b10 : 2'b11, wr ? wdata : 16'hFFFF};
    endfunction

endpackage

// File: rtl/enet_mdio_ctrl_if.sv
// enet_mdio_ctrl_if: single-register command/response bus between the core-side
// bus glue (master) and the MDIO controller (slave).
interface enet_mdio_ctrl_if;

    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [4:0]  cmd_phy;
    logic [4:0]  cmd_reg;
    logic [15:0] cmd_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output cmd_valid, cmd_write, cmd_phy, cmd_reg, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_phy, cmd_reg, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/enet_mdio_clkdiv.sv
// enet_mdio_clkdiv: enable-gated MDC generator; CLK_DIV cycles low then CLK_DIV
// high, restarting low on enable, with one-cycle rise/fall strobes.
module enet_mdio_clkdiv #(
    parameter int CLK_DIV = 25
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    output logic mdc_o,
    output logic rise,
    output logic fall
);

    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] cnt_q;
    logic          mdc_q;
    logic          term;

    // Strobes mark the edge on which the registered MDC is about to toggle.
    assign term  = en_i && cnt_q == CW'(CLK_DIV - 1);
    assign rise  = term && !mdc_q;
    assign fall  = term && mdc_q;
    assign mdc_o = mdc_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni || !en_i) begin
            cnt_q <= '0;
            mdc_q <= 1'b0;
        end else if (term) begin
            cnt_q <= '0;
            mdc_q <= !mdc_q;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/enet_mdio_ctrl.sv
// enet_mdio_ctrl: Clause 22 MDIO master with PHY hardware reset sequencing.
// Define ENET_MDIO_PHY_RST_EN to include the timed PHY reset hold/wait states.
module enet_mdio_ctrl
    import enet_mdio_pkg::*;
#(
    parameter int CLK_DIV      = 25,
    parameter int PHY_RST_HOLD = 500000,
    parameter int PHY_RST_WAIT = 500000
) (
    input  logic                   wb_clk,
    input  logic                   wb_rst_n,
    enet_mdio_ctrl_if.slave        bus,
    output logic                   mdc_o,
    output logic                   mdio_o,
    output logic                   mdio_oe,
    input  logic                   mdio_i,
    output logic                   phy_resetn_o,
    output logic                   phy_ready_o
);

    mdio_state_e                state_q;
    logic [MDIO_FRAME_BITS-1:0] sr_q;
    logic [5:0]                 bit_q;
    logic                       write_q;
    logic                       rx_q;
    logic                       oe_q;
    logic                       rsp_valid_q;
    logic                       rsp_err_q;
    logic [15:0]                rsp_rdata_q;
    logic                       phy_ready_q;
    logic                       rise;
    logic                       fall;

`ifdef ENET_MDIO_PHY_RST_EN
    localparam int RST_MAX   = PHY_RST_HOLD > PHY_RST_WAIT ? PHY_RST_HOLD : PHY_RST_WAIT;
    localparam int RST_CNT_W = $clog2(RST_MAX < 2 ? 2 : RST_MAX);

    logic [RST_CNT_W-1:0] rst_cnt_q;
    logic                 phy_resetn_q;

    assign phy_resetn_o = phy_resetn_q;
`else
    assign phy_resetn_o = 1'b1;
`endif

    assign bus.cmd_ready = state_q == IDLE;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign mdio_o        = sr_q[MDIO_FRAME_BITS-1];
    assign mdio_oe       = oe_q;
    assign phy_ready_o   = phy_ready_q;

    enet_mdio_clkdiv #(.CLK_DIV(CLK_DIV)) u_clkdiv (
        .clk_i  (wb_clk),
        .rst_ni (wb_rst_n),
        .en_i   (state_q == SHIFT),
        .mdc_o  (mdc_o),
        .rise   (rise),
        .fall   (fall)
    );

    // Received bits enter sr_q at the bottom while frame bits leave at the top,
    // so after the last bit the low end holds the turnaround sample and data.
    always_ff @(posedge wb_clk) begin
        if (!wb_rst_n) begin
            state_q     <= RST_HOLD;
            sr_q        <= '1;
            bit_q       <= '0;
            write_q     <= 1'b0;
            rx_q        <= 1'b0;
            oe_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            phy_ready_q <= 1'b0;
`ifdef ENET_MDIO_PHY_RST_EN
            rst_cnt_q    <= '0;
            phy_resetn_q <= 1'b0;
`endif
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
`ifdef ENET_MDIO_PHY_RST_EN
                RST_HOLD: if (rst_cnt_q == RST_CNT_W'(PHY_RST_HOLD - 1)) begin
                    state_q      <= RST_WAIT;
                    rst_cnt_q    <= '0;
                    phy_resetn_q <= 1'b1;
                end else begin
                    rst_cnt_q <= rst_cnt_q + 1'b1;
                end
                RST_WAIT: if (rst_cnt_q == RST_CNT_W'(PHY_RST_WAIT - 1)) begin
                    state_q     <= IDLE;
                    phy_ready_q <= 1'b1;
                end else begin
                    rst_cnt_q <= rst_cnt_q + 1'b1;
                end
`else
                RST_HOLD: begin
                    state_q     <= IDLE;
                    phy_ready_q <= 1'b1;
                end
`endif
                IDLE: if (bus.cmd_valid) begin
                    state_q <= SHIFT;
                    sr_q    <= mdio_frame(bus.cmd_write, bus.cmd_phy, bus.cmd_reg, bus.cmd_wdata);
                    write_q <= bus.cmd_write;
                    bit_q   <= '0;
                    oe_q    <= 1'b1;
                end
                SHIFT: begin
                    if (rise)
                        rx_q <= mdio_i;
                    if (fall && bit_q == 6'(MDIO_FRAME_BITS - 1)) begin
                        state_q     <= DONE;
                        sr_q        <= '1;
                        oe_q        <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= write_q ? 16'h0000
                                     : {sr_q[MDIO_FRAME_BITS-2-MDIO_DATA_FIRST:0], rx_q};
                        rsp_err_q   <= !write_q && sr_q[MDIO_FRAME_BITS-2-MDIO_TA_BIT];
                    end else if (fall) begin
                        sr_q  <= {sr_q[MDIO_FRAME_BITS-2:0], rx_q};
                        bit_q <= bit_q + 1'b1;
                        oe_q  <= write_q || bit_q < 6'(MDIO_TA_BIT - 2);
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
